// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC controller: owns the fetch PC, a direct-mapped table of 2-bit
// branch-history counters, and resolved-branch / mispredict statistics.
module fetch_pc_ctrl #(
  parameter int          BHT_BITS = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] dec_pc_plus_4,
  input  logic [31:0] dec_target,
  input  logic        dec_is_branch,
  input  logic        dec_is_jump,
  input  logic        res_valid,
  input  logic [31:0] res_pc,
  input  logic        res_taken,
  input  logic        res_predicted,
  input  logic [31:0] res_target,
  output logic [31:0] pc,
  output logic        pred_taken,
  output logic        flush,
  output logic [31:0] n_branch,
  output logic [31:0] n_mispredict
);
  localparam int BHT_SIZE = 1 << BHT_BITS;

  logic [31:0]         pc_reg, pc_next, redirect_pc;
  logic [31:0]         n_branch_reg, n_branch_next;
  logic [31:0]         n_mispredict_reg, n_mispredict_next;
  logic [BHT_BITS-1:0] rd_idx, wr_idx;
  logic [1:0]          bht_ctr [BHT_SIZE];

  assign rd_idx = pc_reg[BHT_BITS+1:2];
  assign wr_idx = res_pc[BHT_BITS+1:2];

  // Reset masks both combinational decisions so nothing leaks out of the reset cycle.
  assign flush      = ~reset & res_valid & (res_taken != res_predicted);
  assign pred_taken = ~reset & dec_is_branch & bht_ctr[rd_idx][1];

  genvar gi;
  generate
    for (gi = 0; gi < BHT_SIZE; gi++) begin : g_bht
      logic [1:0] ctr_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          ctr_reg <= 2'b01;
        end else if (res_valid && wr_idx == BHT_BITS'(gi)) begin
          if (res_taken && ctr_reg != 2'b11) begin
            ctr_reg <= ctr_reg + 2'd1;
          end else if (!res_taken && ctr_reg != 2'b00) begin
            ctr_reg <= ctr_reg - 2'd1;
          end
        end
      end
      assign bht_ctr[gi] = ctr_reg;
    end
  endgenerate

  assign redirect_pc = res_taken ? res_target : res_pc + 32'd4;

  always_comb begin
    pc_next = dec_pc_plus_4;
    if (flush) begin
      pc_next = redirect_pc;
    end else if (stall) begin
      pc_next = pc_reg;
    end else if (dec_is_jump || pred_taken) begin
      pc_next = dec_target;
    end
  end

  assign n_branch_next = (res_valid && n_branch_reg != 32'hFFFF_FFFF)
                       ? n_branch_reg + 32'd1 : n_branch_reg;
  assign n_mispredict_next = (flush && n_mispredict_reg != 32'hFFFF_FFFF)
                           ? n_mispredict_reg + 32'd1 : n_mispredict_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg           <= RESET_PC;
      n_branch_reg     <= 32'd0;
      n_mispredict_reg <= 32'd0;
    end else begin
      pc_reg           <= pc_next;
      n_branch_reg     <= n_branch_next;
      n_mispredict_reg <= n_mispredict_next;
    end
  end

  assign pc           = pc_reg;
  assign n_branch     = n_branch_reg;
  assign n_mispredict = n_mispredict_reg;
endmodule

// File: doc/fetch_pc_ctrl.md
# fetch_pc_ctrl

Fetch-stage program-counter controller for the pipelined core. It owns the PC register and a direct-mapped table of 2-bit branch-history counters. Each cycle it chooses the next fetch address from reset, an execute-stage mispredict redirect, a stall hold, or the decode-stage jump/branch prediction. It sits between the fetch-stage PC decoder, which supplies `pc_plus_4`, the target, `is_branch` and `is_jump` for the instruction at `pc`, and the execute-stage branch resolution logic.

## Interface
Parameters:
- `BHT_BITS`, default 6: log2 of the history-table entry count (64 entries).
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `stall` input 1: hazard-unit fetch stall; holds the PC.
- `dec_pc_plus_4` input 32: `pc + 4` from the fetch-stage PC decoder.
- `dec_target` input 32: jump or branch target from the decoder.
- `dec_is_branch` input 1: the instruction at `pc` is beq/bne.
- `dec_is_jump` input 1: the instruction at `pc` is j/jal.
- `res_valid` input 1: a conditional branch resolved in execute this cycle.
- `res_pc` input 32: PC of the resolved branch.
- `res_taken` input 1: actual outcome.
- `res_predicted` input 1: prediction carried down the pipe for that branch.
- `res_target` input 32: actual taken target.
- `pc` output 32: current fetch address (registered).
- `pred_taken` output 1: prediction for the instruction at `pc` (combinational); carried down the pipe as `res_predicted`.
- `flush` output 1: mispredict; younger pipeline stages must squash (combinational).
- `n_branch` output 32: count of resolved branches (registered).
- `n_mispredict` output 32: count of mispredicts (registered).

## Operation
- **History table:** `2**BHT_BITS` entries, each a 2-bit saturating counter.
  - Read index: `pc[BHT_BITS+1:2]`.
  - Update index: `res_pc[BHT_BITS+1:2]`.
  - Counter values: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  - Prediction is counter bit 1.
- **Prediction:** `pred_taken = dec_is_branch & bht[rd_idx][1]`. Jumps are always redirected and do not set `pred_taken`.
- **Mispredict:** `flush = res_valid & (res_taken != res_predicted)`.
- **Redirect address:** `res_taken ? res_target : res_pc + 4`, with 32-bit wrap-around.
- **Next-PC priority, highest first:**
  1. `reset`: `RESET_PC`.
  2. `flush`: redirect address. This overrides `stall`.
  3. `stall`: hold `pc`.
  4. `dec_is_jump`: `dec_target`.
  5. `pred_taken`: `dec_target`.
  6. Otherwise: `dec_pc_plus_4`.
- **Table update:** on `res_valid`, regardless of `stall`.
  - Taken: counter +1, saturating at 11.
  - Not taken: counter −1, saturating at 00.
- **Same-cycle read and update of one entry:** the read returns the pre-update value; there is no bypass.
- **Statistics:**
  - `n_branch` increments on `res_valid`.
  - `n_mispredict` increments on `flush`.
  - Both saturate at 32'hFFFF_FFFF.
- **Inputs not acted on:**
  - `dec_*` inputs are ignored while `stall`, `flush` or `reset` is asserted.
  - `res_*` inputs are ignored while `res_valid` is 0.

## Timing
- **Reset (synchronous, one edge):**
  - `pc = RESET_PC`.
  - Every table entry = 01.
  - `n_branch = 0`, `n_mispredict = 0`.
  - `pred_taken`, `flush` and table updates are masked during the reset cycle.
- **Reset mid-operation:** reset wins over a concurrent `flush` or `res_valid`. Neither the table nor the counters update on that edge.
- **Latency:**
  - Next-PC choice becomes visible on `pc` one cycle later.
  - A redirect lands on the edge that sees `flush`; the correct-path fetch follows in the next cycle.
- **Table latency:** an update is visible to reads from the following cycle.
- **Combinational paths:**
  - `flush` and `pred_taken` depend combinationally on current inputs and state only.
  - There is no combinational path from `res_*` to `pred_taken`.
- **Simultaneous events:**
  - `flush` with `stall`: redirect taken.
  - `flush` with `dec_is_jump`: redirect taken.
  - `res_valid` with `stall`: table and counters still update.

## Test plan
- **Reset:** `RESET_PC` = 32'h0000_3000; hold reset 2 cycles with `res_valid` = 1 → `pc` = 32'h3000; `n_branch` = 0; entry read at `pc` 0x3000 predicts not-taken.
- **Sequential fetch and jump:**
  - `pc` = 0x100, no branch → next `pc` = 0x104.
  - `dec_is_jump` = 1, `dec_target` = 0x400 → next `pc` = 0x400; `pred_taken` = 0.
- **Training:**
  - Resolve `res_pc` = 0x200 taken once → its entry goes 01 → 10.
  - Then fetch at `pc` = 0x200 with `dec_is_branch` = 1 and `dec_target` = 0x280 → `pred_taken` = 1, next `pc` = 0x280.
  - 3 more taken resolutions → entry saturates at 11.
  - One not-taken resolution → 10.
- **Mispredict with stall:** `stall` = 1, `res_valid` = 1, `res_pc` = 0x200, `res_taken` = 0, `res_predicted` = 1 → `flush` = 1; next `pc` = 0x204; `n_mispredict` increments by 1.
- **Mispredict taken:** `res_taken` = 1, `res_predicted` = 0, `res_target` = 0x800 → next `pc` = 0x800 even with `dec_is_jump` = 1 and `dec_target` = 0x400.
- **Edge cases:**
  - `res_pc` = 32'hFFFF_FFFC not-taken mispredict → next `pc` = 0x0000_0000.
  - Counter preloaded to 32'hFFFF_FFFF, then `res_valid` → stays 32'hFFFF_FFFF.
